// File: rtl/packer_arb_pkg.sv
// Shared types for the packer stream arbiter.
// State encoding for the grant/flush sequencer.
package packer_arb_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbPass,
    ArbFlush,
    ArbFlushWait
  } arb_st_e;

endpackage

// File: rtl/packer_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or above ptr, wrapping.
module packer_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  logic [IW-1:0] idx;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) grant = idx;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/packer_stream_arb.sv
// Round-robin sharing of one packer between NumReq streams.
// Each packet is flushed before the next grant.
module packer_stream_arb
  import packer_arb_pkg::*;
#(
  parameter  int NumReq = 4,
  parameter  int InW    = 32,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [NumReq*InW-1:0] req_data_i,
  input  logic [NumReq*InW-1:0] req_mask_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic                  pk_valid_o,
  output logic [InW-1:0]        pk_data_o,
  output logic [InW-1:0]        pk_mask_o,
  input  logic                  pk_ready_i,
  output logic                  pk_flush_o,
  input  logic                  pk_flush_done_i,
  output logic [IdxW-1:0]       owner_o,
  output logic                  busy_o,
  output logic                  err_o
);

  arb_st_e         st_q, st_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic            err_q;
  logic [IdxW-1:0] pick;
  logic            any_req;
  logic            own_valid;
  logic            own_last;
  logic [InW-1:0]  own_data;
  logic [InW-1:0]  own_mask;
  logic            hs;

  packer_rr_pick #(
    .N  (NumReq),
    .IW (IdxW)
  ) u_pick (
    .req     (req_valid_i),
    .ptr     (rr_q),
    .grant   (pick),
    .any_req (any_req)
  );

  assign own_valid = req_valid_i[owner_q];
  assign own_last  = req_last_i[owner_q];
  assign own_data  = req_data_i[owner_q*InW +: InW];
  assign own_mask  = req_mask_i[owner_q*InW +: InW];
  assign hs        = (st_q == ArbPass) & own_valid & pk_ready_i;

  always_comb begin
    st_d        = st_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    pk_valid_o  = 1'b0;
    pk_data_o   = '0;
    pk_mask_o   = '0;
    pk_flush_o  = 1'b0;
    req_ready_o = '0;
    busy_o      = 1'b1;
    unique case (st_q)
      ArbIdle: begin
        busy_o = 1'b0;
        if (any_req) begin
          owner_d = pick;
          st_d    = ArbPass;
        end
      end
      ArbPass: begin
        pk_valid_o           = own_valid;
        pk_data_o            = own_data;
        pk_mask_o            = own_mask;
        // Ready must not depend on req_valid_i.
        req_ready_o[owner_q] = pk_ready_i;
        if (hs && own_last) st_d = ArbFlush;
      end
      ArbFlush: begin
        pk_flush_o = 1'b1;
        st_d       = ArbFlushWait;
      end
      ArbFlushWait: begin
        if (pk_flush_done_i) begin
          rr_d = (owner_q == IdxW'(NumReq - 1)) ? '0
                                                : owner_q + 1'b1;
          st_d = ArbIdle;
        end
      end
      default: st_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= ArbIdle;
      owner_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      if (pk_flush_done_i && st_q != ArbFlushWait) err_q <= 1'b1;
    end
  end

  // The owner field is only meaningful while busy.
  assign owner_o = busy_o ? owner_q : '0;
  assign err_o   = err_q;

endmodule

// File: doc/packer_stream_arb.md
Name: packer_stream_arb

Overview:
Round-robin arbiter and sequencer that shares one byte/bit packer instance between NumReq independent input streams. It grants one stream at a time and forwards its beats to the packer. When the stream's last beat is accepted, it issues a packer flush and waits for flush completion before re-arbitrating. This keeps packets from different requesters from being merged in the packer's storage. It also enforces the packer's input rules: flush is never asserted together with valid, and valid stays quiet during a flush.

Parameters:
NumReq, 4, number of requesting streams (>=2)
InW, 32, packer input data/mask width
IdxW (localparam), $clog2(NumReq), owner index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  NumReq  per-requester beat valid
req_data_i  in  NumReq*InW  per-requester data, requester i at [i*InW+:InW]
req_mask_i  in  NumReq*InW  per-requester mask (contiguous ones), same packing
req_last_i  in  NumReq  beat is last of the packet
req_ready_o  out  NumReq  per-requester beat accept
pk_valid_o  out  1  to packer valid_i
pk_data_o  out  InW  to packer data_i
pk_mask_o  out  InW  to packer mask_i
pk_ready_i  in  1  from packer ready_o
pk_flush_o  out  1  to packer flush_i
pk_flush_done_i  in  1  from packer flush_done_o
owner_o  out  IdxW  current grantee; valid only when busy_o
busy_o  out  1  a grant or flush is in progress
err_o  out  1  sticky protocol error

Behaviour:
- State machine: Idle, Pass, Flush, FlushWait. Reset state is Idle, with rr_ptr=0, owner=0 and err_o=0.
- Output reset values: every output is 0 in reset/Idle.
- Idle:
  - If |req_valid_i, pick the first requester with valid set, scanning from rr_ptr upward with wrap.
  - Register it as owner and go to Pass. This gives 1 cycle of arbitration latency.
  - If no requester is valid, stay in Idle.
- Pass:
  - pk_valid_o = req_valid_i[owner]; pk_data_o and pk_mask_o are muxed from owner.
  - req_ready_o[owner] = pk_ready_i; all other req_ready_o bits are 0.
  - A handshake is pk_valid_o & pk_ready_i.
  - A handshake with req_last_i[owner]=1 goes to Flush. Otherwise stay in Pass.
  - Non-owners are never granted mid-packet, regardless of their valids.
- Flush:
  - pk_flush_o=1 for exactly one cycle; pk_valid_o=0. Next state is FlushWait.
- FlushWait:
  - pk_flush_o=0, pk_valid_o=0, all req_ready_o bits 0.
  - On pk_flush_done_i=1: rr_ptr <= owner+1 (wrap to 0 at NumReq-1), go to Idle.
  - There is no timeout.
- busy_o is 1 in Pass, Flush and FlushWait. owner_o = owner register.
- Requester rule: req_valid_i held until accepted, with data/mask/last stable. The bench asserts this.
- Zero-mask beats are forwarded as-is. A zero-mask last beat still triggers a flush.
- pk_flush_done_i outside FlushWait sets err_o. err_o is sticky until reset and has no other effect on the state machine.
- Latency:
  - 1 idle cycle before the first beat of a grant.
  - After the last beat, at least 3 cycles until the next grant: Flush, then FlushWait with the packer's done, then Idle.
- Asynchronous reset mid-packet aborts immediately. Packer state is the reset domain's responsibility; no flush is issued.
- No combinational path from req_valid_i to any req_ready_o. A path from pk_ready_i to req_ready_o is allowed.

Decomposition:
- Shared package packer_arb_pkg: state enum arb_st_e {ArbIdle, ArbPass, ArbFlush, ArbFlushWait}, 2 bits.
- Sub-module packer_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any_req.
  - Reusable elsewhere.

Test Plan:
- Single stream, NumReq=4, InW=32. Req1 sends 3 beats of mask 0x0000FFFF, last on beat 3, packer always ready.
  -> owner_o=1 from cycle 1; pk_flush_o pulses once, 1 cycle after the 3rd handshake; done returns; busy_o drops; rr_ptr=2.
- All 4 requesters continuously valid, 1-beat packets.
  -> grant order 0,1,2,3,0; no two owners' beats interleave between flush pulses.
- Req2 mid-packet with req0 valid, pk_ready_i low for 5 cycles.
  -> req_ready_o=0 for all; pk_data_o stable and equal to req2's data; req0 not granted until after req2's flush_done.
- pk_flush_done_i pulsed while in Pass.
  -> err_o=1 next cycle and stays 1; the packet continues normally.
- rst_ni asserted in FlushWait.
  -> all outputs 0 immediately; after release, Idle grants from req0.
- Protocol checks throughout all tests: never pk_flush_o & pk_valid_o; pk_valid_o=0 in Flush/FlushWait.
